// File: rtl/display_mode_ctrl.sv
// Display channel selector with NORM/SET/ALARM mode FSM, blink and timeout.
// Optional AUTO_SCROLL_EN: timed channel auto-advance while in NORM.
module display_mode_ctrl #(
    parameter int DW           = 4,
    parameter int NCH          = 4,
    parameter int CW           = 2,
    parameter int TO_W         = 8,
    parameter int TIMEOUT      = 100,
    parameter int BLINK_DIV    = 50,
    parameter int SCROLL_TICKS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_next,
    input  logic              btn_mode,
    input  logic              alarm_hit,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [DW-1:0]     alarm_data,
    output logic [DW-1:0]     o,
    output logic [CW-1:0]     ch_sel,
    output logic [1:0]        mode,
    output logic              blank
);

    typedef enum logic [1:0] {
        NORM  = 2'b00,
        SET   = 2'b01,
        ALARM = 2'b10
    } mode_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] BL_LAST = TO_W'(BLINK_DIV - 1);

    if (NCH < 2 || (2 ** CW) < NCH || SCROLL_TICKS < 1) begin : g_bad_cfg
        $error("display_mode_ctrl: bad parameters");
    end

    mode_e            mode_q, mode_d;
    logic [CW-1:0]    ch_q, ch_d, ch_nxt;
    logic [TO_W-1:0]  to_q, to_d;
    logic [TO_W-1:0]  bl_q, bl_d;
    logic             ph_q, ph_d;
    logic             ack_q, ack_d;
    logic [DW-1:0]    o_q, o_d, chv;
    logic             blank_q, blank_d;
    logic             btn, enter;

`ifdef AUTO_SCROLL_EN
    localparam int SW = $clog2(SCROLL_TICKS + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(SCROLL_TICKS - 1);
    logic [SW-1:0] sc_q, sc_d;
`endif

    always_comb begin
        chv = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_q == CW'(k)) chv = ch_data[k*DW +: DW];
        end
    end

    assign ch_nxt = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
    assign btn    = btn_next | btn_mode;
    assign enter  = alarm_hit && !ack_q && (mode_q != ALARM);

    always_comb begin
        mode_d = mode_q;
        ch_d   = ch_q;
        to_d   = to_q;
        bl_d   = bl_q;
        ph_d   = ph_q;
        ack_d  = ack_q;
        if (tick) begin
            if (bl_q == BL_LAST) begin
                bl_d = '0;
                ph_d = !ph_q;
            end else begin
                bl_d = bl_q + TO_W'(1);
            end
        end
        unique case (mode_q)
            NORM: begin
                if (enter)         mode_d = ALARM;
                else if (btn_mode) mode_d = SET;
                else if (btn_next) ch_d   = ch_nxt;
            end
            SET: begin
                if (enter)         mode_d = ALARM;
                else if (btn_mode) mode_d = NORM;
                else if (btn_next) begin
                    ch_d = ch_nxt;
                    to_d = '0;
                end else if (tick) begin
                    if (to_q == TO_LAST) mode_d = NORM;
                    else                 to_d   = to_q + TO_W'(1);
                end
            end
            ALARM: begin
                if (btn) begin
                    mode_d = NORM;
                    ack_d  = 1'b1;
                end else if (!alarm_hit) begin
                    mode_d = NORM;
                end
            end
            default: mode_d = NORM;
        endcase
        if (mode_d != mode_q) to_d = '0;
        // Each entry into SET or ALARM restarts the blink visible
        if (mode_d != mode_q && mode_d != NORM) begin
            bl_d = '0;
            ph_d = 1'b1;
        end
        if (!alarm_hit) ack_d = 1'b0;
`ifdef AUTO_SCROLL_EN
        sc_d = sc_q;
        if (mode_q != NORM || mode_d != NORM || btn) begin
            sc_d = '0;
        end else if (tick) begin
            if (sc_q == SC_LAST) begin
                sc_d = '0;
                ch_d = ch_nxt;
            end else begin
                sc_d = sc_q + SW'(1);
            end
        end
`endif
    end

    always_comb begin
        o_d     = chv;
        blank_d = 1'b0;
        unique case (mode_q)
            NORM:  o_d = chv;
            SET: begin
                o_d     = ph_q ? chv : '0;
                blank_d = !ph_q;
            end
            ALARM: o_d = ph_q ? alarm_data : chv;
            default: o_d = chv;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= NORM;
            ch_q    <= '0;
            to_q    <= '0;
            bl_q    <= '0;
            ph_q    <= 1'b1;
            ack_q   <= 1'b0;
            o_q     <= '0;
            blank_q <= 1'b0;
`ifdef AUTO_SCROLL_EN
            sc_q    <= '0;
`endif
        end else begin
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            to_q    <= to_d;
            bl_q    <= bl_d;
            ph_q    <= ph_d;
            ack_q   <= ack_d;
            o_q     <= o_d;
            blank_q <= blank_d;
`ifdef AUTO_SCROLL_EN
            sc_q    <= sc_d;
`endif
        end
    end

    assign o      = o_q;
    assign ch_sel = ch_q;
    assign mode   = mode_q;
    assign blank  = blank_q;

endmodule
